// File: rtl/bcd_ex3_serial_conv_if.sv
// Handshake bundle for the serial BCD <-> Excess-3 converter: input word
// channel and converted output word channel.
`timescale 1ns/1ps
interface bcd_ex3_serial_conv_if #(parameter int DIGITS = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [DIGITS*4-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIGITS*4-1:0]   out_data;
  logic                  out_mode;
  logic                  out_err;
  logic [DIGITS-1:0]     out_err_mask;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_err, out_err_mask
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_err, out_err_mask
  );
endinterface

// File: rtl/bcd_ex3_serial_conv.sv
// Digit-serial BCD <-> Excess-3 converter: one digit per cycle, LSD first,
// result presented with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an input word
// CONV  | converting digit[cnt_q], one per cycle
// HOLD  | result valid, waiting for out_ready
`timescale 1ns/1ps
module bcd_ex3_serial_conv #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_ex3_serial_conv_if.slave bus,
  output logic                 busy
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W  = DIGITS * 4;

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [W-1:0]      wrk_q, wrk_d, odata_q;
  logic [DIGITS-1:0] msk_q, msk_d, omsk_q;
  logic              mode_q, omode_q;
  logic              in_ready, out_valid, accept, last;
  logic [3:0]        src, res;
  logic              bad;

  always_comb begin
    src = 4'h0;
    for (int i = 0; i < DIGITS; i++)
      if (cnt_q == CW'(i)) src = wrk_q[i*4 +: 4];
  end

  always_comb begin
    res = 4'h0;
    bad = 1'b0;
    if (!mode_q) begin
      if (src <= 4'd9) res = src + 4'd3;
      else begin
        res = 4'hF;
        bad = 1'b1;
      end
    end else begin
      if (src >= 4'd3 && src <= 4'd12) res = src - 4'd3;
      else begin
        res = 4'hF;
        bad = 1'b1;
      end
    end
  end

  // Converted digit is written back in place over its source digit.
  always_comb begin
    wrk_d = wrk_q;
    msk_d = msk_q;
    for (int i = 0; i < DIGITS; i++)
      if (cnt_q == CW'(i)) begin
        wrk_d[i*4 +: 4] = res;
        msk_d[i]        = bad;
      end
  end

  assign last   = (cnt_q == CW'(DIGITS - 1));
  assign accept = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          in_ready = 1'b1;
          state_d  = bus.in_valid ? CONV : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
    end
  end

  // Output registers only load on the last digit so they stay stable
  // through IDLE/CONV and carry the previous result until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      wrk_q   <= '0;
      msk_q   <= '0;
      mode_q  <= 1'b0;
      odata_q <= '0;
      omsk_q  <= '0;
      omode_q <= 1'b0;
    end else if (accept) begin
      wrk_q  <= bus.in_data;
      mode_q <= bus.in_mode;
      cnt_q  <= '0;
      msk_q  <= '0;
    end else if (state_q == CONV) begin
      wrk_q <= wrk_d;
      msk_q <= msk_d;
      if (last) begin
        cnt_q   <= '0;
        odata_q <= wrk_d;
        omsk_q  <= msk_d;
        omode_q <= mode_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = odata_q;
  assign bus.out_mode     = omode_q;
  assign bus.out_err_mask = omsk_q;
  assign bus.out_err      = |omsk_q;

endmodule

// File: tb/tb_bcd_ex3_serial_conv.sv
// Directed scoreboard bench for bcd_ex3_serial_conv with DIGITS=4.
`timescale 1ns/1ps
module tb_bcd_ex3_serial_conv;

  typedef struct packed {
    logic [15:0] data;
    logic        mode;
    logic [3:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  bcd_ex3_serial_conv_if #(.DIGITS(4)) bus ();

  bcd_ex3_serial_conv #(.DIGITS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [15:0] d, input logic m);
    exp_t e;
    logic [3:0] v;
    e.data = '0;
    e.mask = '0;
    e.mode = m;
    for (int i = 0; i < 4; i++) begin
      v = d[i*4 +: 4];
      if (!m) begin
        if (v < 4'd10) e.data[i*4 +: 4] = v + 4'd3;
        else begin e.data[i*4 +: 4] = 4'hF; e.mask[i] = 1'b1; end
      end else begin
        if (v > 4'd2 && v < 4'd13) e.data[i*4 +: 4] = v - 4'd3;
        else begin e.data[i*4 +: 4] = 4'hF; e.mask[i] = 1'b1; end
      end
    end
    return e;
  endfunction

  // Offer one word, wait (bounded) for acceptance, push its expected result.
  task automatic offer(input string tag, input logic [15:0] d, input logic m, input exp_t e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    while (!bus.in_ready && n < 20) begin step(); n++; end
    chk({tag, "_accept"}, bus.in_ready, 1'b1);
    sb.push_back(e);
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    bus.in_mode  = 1'($urandom);
  endtask

  task automatic wait_out(input string tag, input int lat);
    int n = 0;
    while (!bus.out_valid && n < 20) begin step(); n++; end
    chk({tag, "_latency"}, n, lat);
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_data"},  bus.out_data, e.data);
      chk({tag, "_mode"},  bus.out_mode, e.mode);
      chk({tag, "_mask"},  bus.out_err_mask, e.mask);
      chk({tag, "_err"},   bus.out_err, |e.mask);
    end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_drop_valid"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    exp_t e;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    step();
    step();
    chk("rst_in_ready_low", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready_high", bus.in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", bus.out_data, 16'h0);
    chk("rst_out_mask", bus.out_err_mask, 4'h0);
    chk("rst_out_err", bus.out_err, 1'b0);
    chk("rst_out_mode", bus.out_mode, 1'b0);

    e = '{data: 16'h4567, mode: 1'b0, mask: 4'b0000};
    offer("m0", 16'h1234, 1'b0, e);
    chk("m0_busy", busy, 1'b1);
    wait_out("m0", 4);
    check_front("m0");
    consume("m0");

    e = '{data: 16'h1234, mode: 1'b1, mask: 4'b0000};
    offer("m1", 16'h4567, 1'b1, e);
    wait_out("m1", 4);
    check_front("m1");
    consume("m1");

    e = '{data: 16'hCF38, mode: 1'b0, mask: 4'b0100};
    offer("m0_bad", 16'h9A05, 1'b0, e);
    wait_out("m0_bad", 4);
    check_front("m0_bad");
    consume("m0_bad");

    e = '{data: 16'h09FF, mode: 1'b1, mask: 4'b0011};
    offer("m1_bad", 16'h3C02, 1'b1, e);
    wait_out("m1_bad", 4);
    check_front("m1_bad");
    consume("m1_bad");

    offer("mdl0", 16'h0909, 1'b0, model(16'h0909, 1'b0));
    wait_out("mdl0", 4);
    check_front("mdl0");
    consume("mdl0");

    offer("mdl1", 16'hFC3D, 1'b1, model(16'hFC3D, 1'b1));
    wait_out("mdl1", 4);
    check_front("mdl1");
    consume("mdl1");

    // Backpressure, then back-to-back accept of 0000 while draining.
    e = '{data: 16'h4567, mode: 1'b0, mask: 4'b0000};
    offer("bp", 16'h1234, 1'b0, e);
    wait_out("bp", 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_in_ready", bus.in_ready, 1'b0);
      chk("bp_hold_data", bus.out_data, 16'h4567);
      step();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0000;
    bus.in_mode   = 1'b0;
    #1;
    chk("b2b_in_ready", bus.in_ready, 1'b1);
    check_front("bp");
    sb.push_back('{data: 16'h3333, mode: 1'b0, mask: 4'b0000});
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_valid_low", bus.out_valid, 1'b0);
    wait_out("b2b", 4);
    check_front("b2b");
    consume("b2b");

    // Reset on the second cycle of CONV discards the word.
    offer("rmid", 16'h9876, 1'b0, model(16'h9876, 1'b0));
    step();
    rst = 1'b1;
    step();
    chk("rmid_in_ready_rst", bus.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_valid", bus.out_valid, 1'b0);
    chk("rmid_data", bus.out_data, 16'h0);
    chk("rmid_mask", bus.out_err_mask, 4'h0);
    chk("rmid_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rmid_no_output", bus.out_valid, 1'b0);
    end

    e = '{data: 16'h1234, mode: 1'b1, mask: 4'b0000};
    offer("post_rst", 16'h4567, 1'b1, e);
    wait_out("post_rst", 4);
    check_front("post_rst");
    consume("post_rst");
    chk("end_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_ex3_serial_conv.md
BCD_EX3_SERIAL_CONV -- requirements
Module: bcd_ex3_serial_conv

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of 4-bit digits per word (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, input word offered.
REQ-005 SHALL have port in_ready, output, 1, block can accept input word this cycle.
REQ-006 SHALL have port in_mode, input, 1, conversion direction: 0 = BCD->Excess-3, 1 = Excess-3->BCD.
REQ-007 SHALL have port in_data, input, DIGITS*4, packed digits; digit i at bits [i*4 +: 4]; digit 0 is least significant.
REQ-008 SHALL have port out_valid, output, 1, converted word available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts output word.
REQ-010 SHALL have port out_data, output, DIGITS*4, converted digits in the same packing as in_data.
REQ-011 SHALL have port out_mode, output, 1, copy of in_mode for the word on out_data.
REQ-012 SHALL have port out_err, output, 1, OR of out_err_mask.
REQ-013 SHALL have port out_err_mask, output, DIGITS, bit i set when source digit i was an invalid code.
REQ-014 SHALL have port busy, output, 1, high in CONV state.

Function
REQ-015 SHALL implement FSM states IDLE, CONV, HOLD.
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==HOLD & out_ready).
REQ-017 SHALL capture in_data and in_mode into internal registers on handshake (in_valid & in_ready), clear the digit counter and err mask, and enter CONV.
REQ-018 SHALL ignore in_data and in_mode when no handshake occurs.
REQ-019 In CONV, SHALL convert exactly one digit per cycle, digit index = counter, LSD first; counter width is clog2(DIGITS), minimum 1 bit.
REQ-020 Mode 0 conversion: a source digit 0..9 SHALL produce digit+3 (mod 16); a source digit 10..15 SHALL produce 4'hF and set its mask bit.
REQ-021 Mode 1 conversion: a source digit 3..12 SHALL produce digit-3; a source digit 0..2 or 13..15 SHALL produce 4'hF and set its mask bit.
REQ-022 After converting digit DIGITS-1, SHALL enter HOLD with out_valid=1 on the next cycle; latency from handshake edge to out_valid high SHALL be exactly DIGITS cycles.
REQ-023 SHALL hold out_valid high, and SHALL hold out_data, out_mode, out_err and out_err_mask stable, throughout HOLD until out_ready=1.
REQ-024 In HOLD with out_ready=1 and in_valid=0, SHALL go to IDLE, with out_valid=0 on the next cycle.
REQ-025 In HOLD with out_ready=1 and in_valid=1, SHALL complete the output handshake and accept the new word in the same cycle, then go directly to CONV; no bubble.
REQ-026 SHALL never assert out_valid outside HOLD.
REQ-027 In IDLE and CONV, out_data and the mask SHALL retain their last values; consumers use them only when out_valid=1.
REQ-028 DIGITS=1 SHALL yield CONV lasting one cycle (latency 1).

Reset
REQ-029 With rst=1 at a clock edge, SHALL enter IDLE, and SHALL clear counter, out_data, out_mode, out_err_mask and out_err to 0.
REQ-030 Reset outputs: out_valid=0, busy=0; in_ready=0 while rst=1, and in_ready=1 on the first cycle after rst is released.
REQ-031 Reset asserted mid-CONV or mid-HOLD SHALL discard the in-flight word; no partial output SHALL be presented.
REQ-032 rst SHALL take priority over any simultaneous handshake.

Verification (DIGITS=4)
REQ-033 SHALL verify mode 0 conversion: in_data=16'h1234 -> out_data=16'h4567, out_err=0, out_valid rises 4 cycles after the handshake.
REQ-034 SHALL verify mode 1 conversion: in_data=16'h4567 -> out_data=16'h1234, out_mode=1, out_err=0.
REQ-035 SHALL verify mode 0 invalid-digit handling: in_data=16'h9A05 -> out_data=16'hCF38, out_err_mask=4'b0100, out_err=1.
REQ-036 SHALL verify mode 1 invalid-digit handling: in_data=16'h3C02 -> out_data=16'h09FF, out_err_mask=4'b0011.
REQ-037 SHALL verify backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0; then set out_ready=1 with in_valid=1 and word 16'h0000 -> a back-to-back accept, with next out_data=16'h3333 four cycles later.
REQ-038 SHALL verify reset mid-operation: assert rst on the second cycle of CONV -> next cycle is IDLE, out_valid=0, out_data=0; the next accepted word converts correctly.
